udp_tx_arb: RTL and testbench
=============================

UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 Parameter NUM_CH, default 4: number of user transmit channels, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 65535: BUSY watchdog limit in clk cycles, 16 bits.
REQ-003 clk  in  1  single clock, the gmii_tx_clk domain.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ch_req  in  NUM_CH  per-channel level request to send one packet.
REQ-006 ch_byte_num  in  NUM_CH*16  per-channel UDP payload length, channel i at bits [16i+15:16i].
REQ-007 ch_des_ip  in  NUM_CH*32  per-channel destination IP.
REQ-008 ch_des_mac  in  NUM_CH*48  per-channel destination MAC.
REQ-009 ch_data  in  NUM_CH*8  per-channel payload byte.
REQ-010 ch_grant  out  NUM_CH  one-hot owner of the transmitter.
REQ-011 ch_tx_req  out  NUM_CH  payload-byte request, routed to the owner only.
REQ-012 ch_done  out  NUM_CH  one-cycle packet-complete pulse to the owner.
REQ-013 tx_start_en, tx_byte_num[15:0], tx_data[7:0], des_ip[31:0], des_mac[47:0]  out  UDP transmitter user side.
REQ-014 tx_req, tx_done  in  1 each  from the UDP transmitter.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 tx_timeout  out  1  one-cycle watchdog abort pulse.

Function
REQ-017 FSM states: IDLE, START, BUSY. There is no other state.
REQ-018 A channel is eligible when ch_req[i]=1 and ch_byte_num[i]!=0. A zero-length request is never granted.
REQ-019 In IDLE with any channel eligible, the arbiter picks round-robin, searching from last_grant+1 upward with wrap at NUM_CH-1 to 0.
- On that edge: ch_grant, last_grant, tx_byte_num, des_ip and des_mac are registered from the winner.
- Next state is START.
REQ-020 START lasts exactly one cycle with tx_start_en=1, then goes to BUSY. So tx_start_en rises 1 cycle after the sampling edge.
REQ-021 In BUSY:
- tx_data = ch_data of the owner, combinational mux.
- ch_tx_req[owner] = tx_req. All other ch_tx_req bits are 0.
REQ-022 Latched tx_byte_num, des_ip and des_mac stay stable from START until return to IDLE, even if the channel inputs change.
REQ-023 ch_req deassertion after grant is ignored; the packet completes.
REQ-024 When tx_done=1 in BUSY:
- ch_done[owner] pulses on the next cycle.
- ch_grant clears and the state returns to IDLE.
REQ-025 After completion the next grant is sampled at the earliest in the IDLE cycle. Back-to-back packets are therefore separated by 2 idle cycles of tx_start_en.
REQ-026 tx_done outside BUSY and tx_req outside BUSY are ignored.
REQ-027 Outside BUSY, tx_data=0 and all ch_tx_req bits are 0.
REQ-028 Simultaneous requests from all channels are served in strict rotation. No channel waits more than NUM_CH-1 packets.

Reset
REQ-029 While rst=0: state=IDLE, last_grant=NUM_CH-1 (so channel 0 wins first), and every output is 0.
REQ-030 Reset asserted mid-packet aborts immediately with no ch_done pulse. The downstream transmitter is reset by the same rst.

Configuration
REQ-031 With UDP_TX_ARB_TIMEOUT_EN defined, a 16-bit counter runs in BUSY.
- When the counter reaches TIMEOUT_CYC without tx_done: tx_timeout and ch_done[owner] pulse for one cycle, and the state returns to IDLE.
- The counter clears on entry to BUSY.
REQ-032 Without UDP_TX_ARB_TIMEOUT_EN, the counter is absent, tx_timeout is tied 0, and BUSY waits indefinitely for tx_done.

Structure
REQ-033 Shared package udp_pkg holds:
- BYTE_NUM_W=16, IP_W=32, MAC_W=48.
- The FSM state enum.
- Default BOARD/DES MAC and IP constants.
REQ-034 One sub-module, udp_rr_arb: a combinational round-robin one-hot picker taking req and last_grant, returning grant and its index.

Verification
REQ-035 ch_req=4'b0001, byte_num[0]=10, tx_done 12 cycles after tx_start_en -> tx_start_en exactly 1 cycle, 1 cycle after req sampled; ch_done[0] 1 cycle after tx_done.
REQ-036 ch_req=4'b1111, all byte_num=8 -> grant order 0,1,2,3,0; each packet's des_ip/des_mac match its owner's.
REQ-037 ch_req[2]=1 with byte_num[2]=0 plus ch_req[1]=1 -> only channel 1 granted; channel 2 never granted.
REQ-038 rst pulled low 5 cycles into BUSY of channel 3 -> all outputs 0 within the reset, no ch_done; after release channel 0 wins first.
REQ-039 With UDP_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, tx_done withheld -> tx_timeout and ch_done pulse once 100 cycles into BUSY; the next requester is served. Without the macro: busy stays high and tx_timeout stays 0.
REQ-040 ch_byte_num[1] changed from 20 to 30 during BUSY -> tx_byte_num holds 20 until completion.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: field widths, arbiter FSM states and
// default board/destination addressing.
package udp_pkg;

    localparam int BYTE_NUM_W = 16;
    localparam int IP_W       = 32;
    localparam int MAC_W      = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_t;

    // 192.168.1.2 board, 192.168.1.3 default peer
    localparam logic [MAC_W-1:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [IP_W-1:0]  BOARD_IP  = 32'hC0_A8_01_02;
    localparam logic [MAC_W-1:0] DES_MAC   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [IP_W-1:0]  DES_IP    = 32'hC0_A8_01_03;

endpackage

// File: rtl/udp_rr_arb.sv
// Combinational round-robin picker: scans from last_grant+1 upward with
// wrap and returns the one-hot winner plus its index.
module udp_rr_arb
    import udp_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Round-robin arbiter sharing one UDP transmitter among NUM_CH channels.
// Optional BUSY watchdog enabled by defining UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_arb
    import udp_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH*BYTE_NUM_W-1:0] ch_byte_num,
    input  logic [NUM_CH*IP_W-1:0]       ch_des_ip,
    input  logic [NUM_CH*MAC_W-1:0]      ch_des_mac,
    input  logic [NUM_CH*8-1:0]          ch_data,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic [NUM_CH-1:0]            ch_tx_req,
    output logic [NUM_CH-1:0]            ch_done,
    output logic                         tx_start_en,
    output logic [BYTE_NUM_W-1:0]        tx_byte_num,
    output logic [7:0]                   tx_data,
    output logic [IP_W-1:0]              des_ip,
    output logic [MAC_W-1:0]             des_mac,
    input  logic                         tx_req,
    input  logic                         tx_done,
    output logic                         busy,
    output logic                         tx_timeout
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_t        state, next_state;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  last_grant;
    logic              timeout_hit;
    logic              pkt_end;

    // Zero-length requests are never offered to the picker
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_req[i] && (ch_byte_num[i*BYTE_NUM_W +: BYTE_NUM_W] != '0);
        end
    end

    udp_rr_arb #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .valid      (pick_valid)
    );

`ifdef UDP_TX_ARB_TIMEOUT_EN
    logic [15:0] timeout_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt <= '0;
        end else if (state != ST_BUSY) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_BUSY) && !tx_done &&
                         (timeout_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign pkt_end = (state == ST_BUSY) && (tx_done || timeout_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        tx_start_en = 1'b0;
        busy        = 1'b1;
        tx_data     = '0;
        ch_tx_req   = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_valid) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                tx_start_en = 1'b1;
                next_state  = ST_BUSY;
            end
            ST_BUSY: begin
                tx_data               = ch_data[int'(last_grant)*8 +: 8];
                ch_tx_req[last_grant] = tx_req;
                if (pkt_end) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Winner's descriptor is frozen at grant time and held until the next grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_grant    <= '0;
            last_grant  <= IDX_W'(NUM_CH - 1);
            tx_byte_num <= '0;
            des_ip      <= '0;
            des_mac     <= '0;
            ch_done     <= '0;
            tx_timeout  <= 1'b0;
        end else begin
            ch_done    <= '0;
            tx_timeout <= 1'b0;
            if (state == ST_IDLE && pick_valid) begin
                ch_grant    <= pick_grant;
                last_grant  <= pick_idx;
                tx_byte_num <= ch_byte_num[int'(pick_idx)*BYTE_NUM_W +: BYTE_NUM_W];
                des_ip      <= ch_des_ip[int'(pick_idx)*IP_W +: IP_W];
                des_mac     <= ch_des_mac[int'(pick_idx)*MAC_W +: MAC_W];
            end else if (pkt_end) begin
                ch_grant   <= '0;
                ch_done    <= ch_grant;
                tx_timeout <= timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed self-checking bench for udp_tx_arb (4 channels, watchdog of 100
// cycles when UDP_TX_ARB_TIMEOUT_EN is defined).
module tb_udp_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_req;
    logic [63:0]  ch_byte_num;
    logic [127:0] ch_des_ip;
    logic [191:0] ch_des_mac;
    logic [31:0]  ch_data;
    logic [3:0]   ch_grant;
    logic [3:0]   ch_tx_req;
    logic [3:0]   ch_done;
    logic         tx_start_en;
    logic [15:0]  tx_byte_num;
    logic [7:0]   tx_data;
    logic [31:0]  des_ip;
    logic [47:0]  des_mac;
    logic         tx_req;
    logic         tx_done;
    logic         busy;
    logic         tx_timeout;

    int nChecks = 0;
    int nErrors = 0;

    udp_tx_arb #(
        .NUM_CH      (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (ch_req),
        .ch_byte_num (ch_byte_num),
        .ch_des_ip   (ch_des_ip),
        .ch_des_mac  (ch_des_mac),
        .ch_data     (ch_data),
        .ch_grant    (ch_grant),
        .ch_tx_req   (ch_tx_req),
        .ch_done     (ch_done),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_data     (tx_data),
        .des_ip      (des_ip),
        .des_mac     (des_mac),
        .tx_req      (tx_req),
        .tx_done     (tx_done),
        .busy        (busy),
        .tx_timeout  (tx_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ipOf(input int ch);
        return 32'hC0A8_0A00 + 32'(ch);
    endfunction

    function automatic logic [47:0] macOf(input int ch);
        return 48'hAA00_0000_0010 + 48'(ch);
    endfunction

    function automatic logic [7:0] dataOf(input int ch);
        return 8'h11 * 8'(ch + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic req, input logic [15:0] byteNum);
        ch_req[ch]             = req;
        ch_byte_num[ch*16 +: 16] = byteNum;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic waitStart();
        int n;
        n = 0;
        while (tx_start_en !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("start_seen", 64'(tx_start_en), 64'd1);
    endtask

    // Serve one packet from the current START cycle through its done pulse
    task automatic runPacket(input int ch, input int hold);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        waitStart();
        checkOutput($sformatf("grant_ch%0d", ch), 64'(ch_grant), 64'(oh));
        checkOutput($sformatf("ip_ch%0d", ch), 64'(des_ip), 64'(ipOf(ch)));
        checkOutput($sformatf("mac_ch%0d", ch), 64'(des_mac), 64'(macOf(ch)));
        checkOutput($sformatf("len_ch%0d", ch), 64'(tx_byte_num), 64'(ch_byte_num[ch*16 +: 16]));
        tick();
        tx_req = 1'b1;
        #1;
        checkOutput($sformatf("txreq_ch%0d", ch), 64'(ch_tx_req), 64'(oh));
        checkOutput($sformatf("data_ch%0d", ch), 64'(tx_data), 64'(dataOf(ch)));
        repeat (hold) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checkOutput($sformatf("done_ch%0d", ch), 64'(ch_done), 64'(oh));
        checkOutput($sformatf("grant_clr_ch%0d", ch), 64'(ch_grant), 64'd0);
    endtask

    initial begin
        int   n;
        logic seen;

        rst         = 1'b0;
        ch_req      = '0;
        ch_byte_num = '0;
        tx_req      = 1'b0;
        tx_done     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch_des_ip[i*32 +: 32]  = ipOf(i);
            ch_des_mac[i*48 +: 48] = macOf(i);
            ch_data[i*8 +: 8]      = dataOf(i);
        end
        #12;

        $display("[TB] reset state");
        checkOutput("rst_grant", 64'(ch_grant), 64'd0);
        checkOutput("rst_busy", 64'({busy, tx_start_en, tx_timeout}), 64'd0);
        checkOutput("rst_len_ip", 64'({tx_byte_num, des_ip}), 64'd0);
        checkOutput("rst_mac", 64'(des_mac), 64'd0);
        checkOutput("rst_pulses", 64'({ch_done, ch_tx_req, tx_data}), 64'd0);
        rst = 1'b1;
        tick();
        tick();

        $display("[TB] transmitter handshake ignored while idle");
        tx_req  = 1'b1;
        tx_done = 1'b1;
        #1;
        checkOutput("idle_tx_req", 64'(ch_tx_req), 64'd0);
        checkOutput("idle_data", 64'(tx_data), 64'd0);
        tick();
        checkOutput("idle_done", 64'(ch_done), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        tx_req  = 1'b0;
        tx_done = 1'b0;

        $display("[TB] single packet timing");
        applyStimulus(0, 1'b1, 16'd10);
        #1;
        checkOutput("pre_start", 64'(tx_start_en), 64'd0);
        tick();
        checkOutput("start_rise", 64'(tx_start_en), 64'd1);
        checkOutput("start_grant", 64'(ch_grant), 64'b0001);
        checkOutput("start_len", 64'(tx_byte_num), 64'd10);
        applyStimulus(0, 1'b0, 16'd10);
        tick();
        checkOutput("start_one_cycle", 64'(tx_start_en), 64'd0);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        tx_req = 1'b1;
        #1;
        checkOutput("busy_tx_req", 64'(ch_tx_req), 64'b0001);
        checkOutput("busy_data", 64'(tx_data), 64'(dataOf(0)));
        repeat (11) tick();
        checkOutput("busy_hold", 64'({busy, ch_done}), 64'b1_0000);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tx_req  = 1'b0;
        checkOutput("done_next_cycle", 64'(ch_done), 64'b0001);
        checkOutput("done_idle", 64'(busy), 64'd0);
        tick();
        checkOutput("done_one_shot", 64'(ch_done), 64'd0);

        $display("[TB] full rotation");
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 16'd8);
        runPacket(0, 2);
        runPacket(1, 2);
        runPacket(2, 2);
        runPacket(3, 2);
        runPacket(0, 2);
        ch_req = '0;
        tick();
        tick();
        checkOutput("rotation_idle", 64'(busy), 64'd0);

        $display("[TB] zero-length request skipped");
        applyStimulus(2, 1'b1, 16'd0);
        applyStimulus(1, 1'b1, 16'd16);
        runPacket(1, 3);
        applyStimulus(1, 1'b0, 16'd16);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (busy || ch_grant != 4'b0000) seen = 1'b1;
        end
        checkOutput("zero_len_never", 64'(seen), 64'd0);
        applyStimulus(2, 1'b0, 16'd0);

        $display("[TB] descriptor held during packet");
        applyStimulus(1, 1'b1, 16'd20);
        waitStart();
        checkOutput("hold_len_start", 64'(tx_byte_num), 64'd20);
        applyStimulus(1, 1'b0, 16'd30);
        ch_des_ip[32 +: 32] = 32'hDEAD_BEEF;
        repeat (4) tick();
        checkOutput("hold_len_busy", 64'(tx_byte_num), 64'd20);
        checkOutput("hold_ip_busy", 64'(des_ip), 64'(ipOf(1)));
        checkOutput("hold_busy_after_drop", 64'(busy), 64'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("hold_done", 64'(ch_done), 64'b0010);
        ch_des_ip[32 +: 32] = ipOf(1);
        applyStimulus(1, 1'b0, 16'd20);
        tick();

        $display("[TB] reset mid-packet");
        resetDut();
        applyStimulus(3, 1'b1, 16'd12);
        waitStart();
        checkOutput("mid_grant3", 64'(ch_grant), 64'b1000);
        tick();
        tx_req = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'({busy, tx_start_en, tx_timeout}), 64'd0);
        checkOutput("mid_rst_grant", 64'({ch_grant, ch_tx_req, ch_done}), 64'd0);
        checkOutput("mid_rst_data", 64'({tx_data, tx_byte_num, des_ip}), 64'd0);
        checkOutput("mid_rst_mac", 64'(des_mac), 64'd0);
        applyStimulus(0, 1'b1, 16'd6);
        tick();
        checkOutput("mid_rst_no_done", 64'(ch_done), 64'd0);
        tx_req = 1'b0;
        rst    = 1'b1;
        runPacket(0, 3);
        applyStimulus(0, 1'b0, 16'd6);
        runPacket(3, 2);
        applyStimulus(3, 1'b0, 16'd12);
        tick();

        $display("[TB] withheld tx_done");
        applyStimulus(2, 1'b1, 16'd5);
        waitStart();
        checkOutput("wd_grant2", 64'(ch_grant), 64'b0100);
        tick();
        applyStimulus(2, 1'b0, 16'd5);
        applyStimulus(1, 1'b1, 16'd4);
`ifdef UDP_TX_ARB_TIMEOUT_EN
        n = 0;
        while (tx_timeout !== 1'b1 && n < 150) begin
            tick();
            n++;
        end
        checkOutput("wd_cycles", 64'(n), 64'd100);
        checkOutput("wd_done", 64'(ch_done), 64'b0100);
        tick();
        checkOutput("wd_one_shot", 64'({tx_timeout, ch_done}), 64'd0);
`else
        seen = 1'b0;
        repeat (150) begin
            tick();
            if (tx_timeout) seen = 1'b1;
        end
        checkOutput("wd_still_busy", 64'(busy), 64'd1);
        checkOutput("wd_no_timeout", 64'(seen), 64'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("wd_done", 64'(ch_done), 64'b0100);
`endif
        runPacket(1, 2);
        applyStimulus(1, 1'b0, 16'd4);
        tick();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
